ladybird_fetch: RTL

LADYBIRD_FETCH -- requirements
Module: ladybird_fetch

---
 rtl/ladybird_fetch.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ladybird_fetch.sv
// Instruction fetch unit: issues sequential word reads and buffers the returned
// words in an in-order queue toward decode. Redirects flush and kill in-flight reads.
module ladybird_fetch #(
   parameter int              XLEN            = 32,
   parameter logic [XLEN-1:0] RESET_PC        = XLEN'(32'h0000_0000),
   parameter int              QUEUE_DEPTH     = 4,
   parameter int              MAX_OUTSTANDING = 2
) (
   input  logic            clk,
   input  logic            nrst,
   output logic            bus_req,
   input  logic            bus_gnt,
   output logic [XLEN-1:0] bus_addr,
   output logic [3:0]      bus_wstrb,
   input  logic [XLEN-1:0] bus_data,
   input  logic            bus_data_gnt,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc
);

   localparam int QW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int QCW = QW + 1;
   localparam int OW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

   logic [XLEN-1:0] pc_q, pc_d;

   logic [XLEN-1:0] q_inst_q [QUEUE_DEPTH];
   logic [XLEN-1:0] q_inst_d [QUEUE_DEPTH];
   logic [XLEN-1:0] q_pc_q   [QUEUE_DEPTH];
   logic [XLEN-1:0] q_pc_d   [QUEUE_DEPTH];
   logic [QW-1:0]   q_rd_q, q_rd_d, q_wr_q, q_wr_d;
   logic [QCW-1:0]  q_cnt_q, q_cnt_d;

   logic [XLEN-1:0]            o_pc_q [MAX_OUTSTANDING];
   logic [XLEN-1:0]            o_pc_d [MAX_OUTSTANDING];
   logic [MAX_OUTSTANDING-1:0] o_live_q, o_live_d;
   logic [OW-1:0]              o_rd_q, o_rd_d, o_wr_q, o_wr_d;
   logic [OCW-1:0]             o_cnt_q, o_cnt_d;
   logic [OCW-1:0]             live_cnt_q, live_cnt_d;

   logic issue, resp, resp_live, pop;
   logic [31:0] credit_used;
   logic unused_redirect_bits;

   assign unused_redirect_bits = ^redirect_pc[1:0];

   // Killed reads never land in the queue, so only live ones reserve a slot.
   assign credit_used = 32'(q_cnt_q) + 32'(live_cnt_q);
   assign bus_req     = nrst && !redirect_valid
                        && (o_cnt_q < OCW'(MAX_OUTSTANDING))
                        && (credit_used < 32'(QUEUE_DEPTH));
   assign bus_addr    = {pc_q[XLEN-1:2], 2'b00};
   assign bus_wstrb   = 4'b0000;

   assign inst_valid  = (q_cnt_q != '0);
   assign inst        = inst_valid ? q_inst_q[q_rd_q] : '0;
   assign inst_pc     = inst_valid ? q_pc_q[q_rd_q]   : '0;

   assign issue     = bus_req && bus_gnt;
   assign resp      = bus_data_gnt && (o_cnt_q != '0);
   assign resp_live = resp && o_live_q[o_rd_q] && !redirect_valid;
   assign pop       = inst_valid && inst_ready;

   always_comb begin
      pc_d       = pc_q;
      q_inst_d   = q_inst_q;
      q_pc_d     = q_pc_q;
      q_rd_d     = q_rd_q;
      q_wr_d     = q_wr_q;
      q_cnt_d    = q_cnt_q;
      o_pc_d     = o_pc_q;
      o_live_d   = o_live_q;
      o_rd_d     = o_rd_q;
      o_wr_d     = o_wr_q;
      o_cnt_d    = o_cnt_q;
      live_cnt_d = live_cnt_q;

      if (issue) begin
         pc_d             = pc_q + XLEN'(4);
         o_pc_d[o_wr_q]   = {pc_q[XLEN-1:2], 2'b00};
         o_live_d[o_wr_q] = 1'b1;
         o_wr_d           = (o_wr_q == OW'(MAX_OUTSTANDING - 1)) ? '0 : o_wr_q + OW'(1);
      end

      if (resp)
         o_rd_d = (o_rd_q == OW'(MAX_OUTSTANDING - 1)) ? '0 : o_rd_q + OW'(1);

      unique case ({issue, resp})
         2'b10:   o_cnt_d = o_cnt_q + OCW'(1);
         2'b01:   o_cnt_d = o_cnt_q - OCW'(1);
         default: o_cnt_d = o_cnt_q;
      endcase

      if (resp_live) begin
         q_inst_d[q_wr_q] = bus_data;
         q_pc_d[q_wr_q]   = o_pc_q[o_rd_q];
         q_wr_d           = q_wr_q + QW'(1);
      end
      if (pop)
         q_rd_d = q_rd_q + QW'(1);

      unique case ({resp_live, pop})
         2'b10:   q_cnt_d = q_cnt_q + QCW'(1);
         2'b01:   q_cnt_d = q_cnt_q - QCW'(1);
         default: q_cnt_d = q_cnt_q;
      endcase

      unique case ({issue, resp_live})
         2'b10:   live_cnt_d = live_cnt_q + OCW'(1);
         2'b01:   live_cnt_d = live_cnt_q - OCW'(1);
         default: live_cnt_d = live_cnt_q;
      endcase

      // Redirect overrides everything above: in-flight reads stay counted but are dead.
      if (redirect_valid) begin
         pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
         o_live_d   = '0;
         live_cnt_d = '0;
         q_cnt_d    = '0;
         q_rd_d     = '0;
         q_wr_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         pc_q       <= RESET_PC;
         q_rd_q     <= '0;
         q_wr_q     <= '0;
         q_cnt_q    <= '0;
         o_live_q   <= '0;
         o_rd_q     <= '0;
         o_wr_q     <= '0;
         o_cnt_q    <= '0;
         live_cnt_q <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            q_inst_q[i] <= '0;
            q_pc_q[i]   <= '0;
         end
         for (int i = 0; i < MAX_OUTSTANDING; i++)
            o_pc_q[i] <= '0;
      end else begin
         pc_q       <= pc_d;
         q_inst_q   <= q_inst_d;
         q_pc_q     <= q_pc_d;
         q_rd_q     <= q_rd_d;
         q_wr_q     <= q_wr_d;
         q_cnt_q    <= q_cnt_d;
         o_pc_q     <= o_pc_d;
         o_live_q   <= o_live_d;
         o_rd_q     <= o_rd_d;
         o_wr_q     <= o_wr_d;
         o_cnt_q    <= o_cnt_d;
         live_cnt_q <= live_cnt_d;
      end
   end

endmodule
